// File: rtl/byte_packer_pkg.sv
// Shared constants, FSM state type and input-length saturation for the byte packer.
package packer_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  localparam int FILL_W         = 3;

  typedef enum logic {ACCUM, FLUSH} pack_state_t;

  function automatic logic [FILL_W-1:0] sat_len(input logic [31:0] len);
    return (len > 32'(BYTES_PER_WORD)) ? FILL_W'(BYTES_PER_WORD) : len[FILL_W-1:0];
  endfunction
endpackage

// File: rtl/byte_packer_shifter.sv
// Combinational byte aligner: keeps the top len1 bytes of dataIn and places them
// len0 bytes below the top of a double-width, left-justified window.
module Shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0]   dataIn,
  input  logic [LEN_WIDTH-1:0]    len0,
  input  logic [LEN_WIDTH-1:0]    len1,
  output logic [2*DATA_WIDTH-1:0] dataOut,
  output logic [LEN_WIDTH-1:0]    addedLen
);
  logic [DATA_WIDTH-1:0] keep;

  always_comb begin
    keep     = ~({DATA_WIDTH{1'b1}} >> {len1, 3'b000});
    dataOut  = {dataIn & keep, {DATA_WIDTH{1'b0}}} >> {len0, 3'b000};
    addedLen = len0 + len1;
  end
endmodule

// File: rtl/byte_packer.sv
// Packs 0-4 byte chunks into full left-justified words; a frame end flushes the tail
// word with its byte count. Output is registered; in_ready is combinational from out_ready.
module byte_packer
  import packer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_bytes,
  output logic                  out_last
);
  localparam int AW = 2 * DATA_WIDTH;
  localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(BYTES_PER_WORD);

  pack_state_t          state;
  logic [AW-1:0]        acc, acc_pe, acc_nx, shifted;
  logic [FILL_W-1:0]    fill, fill_pe, fill_nx;
  logic [LEN_WIDTH-1:0] added_len;
  logic                 out_free, emit, full_emit, tail_emit, accept;

  assign out_free  = !out_valid || out_ready;
  assign emit      = out_free && ((state == ACCUM && fill >= WORD_FILL) || state == FLUSH);
  assign in_ready  = (state == ACCUM) && (fill < WORD_FILL || emit);
  assign accept    = in_valid && in_ready;
  assign full_emit = emit && (state == ACCUM || fill > WORD_FILL);
  assign tail_emit = emit && !full_emit;

  // The incoming chunk lands behind whatever survives this cycle's emit.
  Shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_shifter (
    .dataIn  (in_data),
    .len0    (LEN_WIDTH'(fill_pe)),
    .len1    (LEN_WIDTH'(sat_len(32'(in_len)))),
    .dataOut (shifted),
    .addedLen(added_len)
  );

  always_comb begin
    acc_pe  = acc;
    fill_pe = fill;
    if (full_emit) begin
      acc_pe  = acc << DATA_WIDTH;
      fill_pe = fill - WORD_FILL;
    end else if (tail_emit) begin
      acc_pe  = '0;
      fill_pe = '0;
    end
    acc_nx  = acc_pe;
    fill_nx = fill_pe;
    if (accept) begin
      acc_nx  = acc_pe | shifted;
      // Sum never exceeds 7; pin rather than wrap should that ever be violated.
      fill_nx = (|added_len[LEN_WIDTH-1:FILL_W]) ? '1 : added_len[FILL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
      out_last  <= 1'b0;
    end else begin
      acc  <= acc_nx;
      fill <= fill_nx;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= acc[AW-1:DATA_WIDTH];
        out_bytes <= full_emit ? 3'(BYTES_PER_WORD) : fill;
        out_last  <= tail_emit;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && in_last) begin
        state <= FLUSH;
      end else if (tail_emit) begin
        state <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: a byte-queue model predicts every output word.
module tb_byte_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  in_len = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       got, expw;

  byte_packer #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_bytes(out_bytes),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got = {out_data, out_bytes, out_last};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL out_word_unexpected got=%h exp=none", got);
      end else begin
        expw = sb.pop_front();
        if (got !== expw) begin
          n_err++;
          $display("FAIL out_word got data=%h bytes=%0d last=%0d exp data=%h bytes=%0d last=%0d",
                   got.d, got.b, got.l, expw.d, expw.b, expw.l);
        end
      end
    end
  end

  task automatic model_push(input logic [31:0] d, input logic [7:0] len, input logic last);
    int n;
    exp_t e;
    logic [7:0] junk;
    n = (len > 8'd4) ? 4 : int'(len);
    for (int i = 0; i < n; i++) mb.push_back(d[31-8*i -: 8]);
    while (mb.size() > 4 || (!last && mb.size() == 4)) begin
      e.d = {mb[0], mb[1], mb[2], mb[3]};
      for (int k = 0; k < 4; k++) junk = mb.pop_front();
      e.b = 3'd4;
      e.l = 1'b0;
      sb.push_back(e);
    end
    if (last) begin
      e.d = '0;
      for (int i = 0; i < mb.size(); i++) e.d[31-8*i -: 8] = mb[i];
      e.b = 3'(mb.size());
      e.l = 1'b1;
      sb.push_back(e);
      mb.delete();
    end
  endtask

  // Drives one beat (don't-care bytes randomised) and waits for acceptance.
  task automatic send(input logic [31:0] d, input logic [7:0] len, input logic last);
    int n;
    int waited;
    logic [31:0] keep;
    logic ok;
    n = (len > 8'd4) ? 4 : int'(len);
    keep = 32'hFFFF_FFFF >> (8 * n);
    keep = ~keep;
    model_push(d & keep, len, last);
    in_valid = 1'b1;
    in_data  = (d & keep) | ($urandom() & ~keep);
    in_len   = len;
    in_last  = last;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 60) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout got in_ready=0 exp in_ready=1 data=%h", d);
    end
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain got pending=%0d exp pending=0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_cmp++; if (out_bytes !== 3'd0) begin n_err++; $display("FAIL reset_out_bytes got=%0d exp=0", out_bytes); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_bytes;
    out_ready = 1'b1;
    send(32'hAA00_0000, 8'd1, 1'b0);
    send(32'h0000_0000, 8'd0, 1'b0);
    send(32'hBB00_0000, 8'd1, 1'b0);
    send(32'hCC00_0000, 8'd1, 1'b0);
    send(32'hDD00_0000, 8'd1, 1'b1);
    wait_drain("single_bytes");
  endtask

  task automatic test_len3;
    send(32'h1122_3300, 8'd3, 1'b0);
    send(32'h4455_6600, 8'd3, 1'b1);
    wait_drain("len3");
  endtask

  task automatic test_backpressure;
    int gaps;
    logic unstable;
    logic [31:0] held;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send({i[7:0], 8'hA5, i[7:0], 8'h5A}, 8'd4, (i == 15));
        end
      end
      begin
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_drop got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        n_cmp++;
        if (sb.size() == 0 || out_data !== sb[0].d) begin
          n_err++;
          $display("FAIL bp_first_word got=%h exp=%h", out_data, (sb.size() != 0) ? sb[0].d : 32'hx);
        end
        held = out_data;
        unstable = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (out_data !== held || out_valid !== 1'b1) unstable = 1'b1;
        end
        n_cmp++; if (unstable !== 1'b0) begin n_err++; $display("FAIL bp_hold got unstable=%b exp=0", unstable); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_held got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        gaps = 0;
        repeat (40) begin
          @(negedge clk);
          if (sb.size() != 0 && !out_valid) gaps++;
        end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL bp_throughput got gaps=%0d exp=0", gaps); end
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_empty_and_sat;
    out_ready = 1'b1;
    send(32'h0000_0000, 8'd0, 1'b1);
    send(32'hA1B2_C3D4, 8'd9, 1'b0);
    send(32'hE500_0000, 8'd1, 1'b1);
    wait_drain("empty_sat");
  endtask

  task automatic test_reset_in_flush;
    logic seen;
    out_ready = 1'b0;
    send(32'h0102_0304, 8'd4, 1'b0);
    send(32'h0A0B_0C00, 8'd3, 1'b0);
    send(32'h0D0E_0F00, 8'd3, 1'b1);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    mb.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flush_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_flush_out_last got=%b exp=0", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_flush_in_ready got=%b exp=1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_flush_no_tail got=%b exp=0", seen); end
    @(posedge clk);
    #1;
    send(32'h7788_0000, 8'd2, 1'b1);
    wait_drain("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_bytes();
    test_len3();
    test_backpressure();
    test_empty_and_sat();
    test_reset_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/byte_packer.md
# byte_packer

Accumulates variable-length byte chunks (0–4 bytes per beat, MSB-first) into a dense stream of full 32-bit words. It sits directly downstream of the compressor's token/literal emitters and drives the output word FIFO. It uses the combinational byte `Shifter` to align each incoming chunk behind the bytes already held. A frame-end marker flushes the partial tail word together with its byte count.

## Interface
Parameters:
- `DATA_WIDTH`, 32: output word width in bits; must be a multiple of 8.
- `LEN_WIDTH`, 8: width of byte-length fields.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat accepted when `in_valid && in_ready` at the rising edge.
- `in_data`, in, DATA_WIDTH: chunk bytes, left-justified; byte 0 is in `[31:24]`; bytes beyond `in_len` are don't-care.
- `in_len`, in, LEN_WIDTH: valid byte count; values greater than 4 saturate to 4.
- `in_last`, in, 1: last beat of frame.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_data`, out, DATA_WIDTH: packed word, left-justified; unused bytes are 0.
- `out_bytes`, out, 3: valid bytes in `out_data`, 0–4.
- `out_last`, out, 1: final word of frame.

## Operation
- State:
  - 64-bit accumulator `acc`, left-justified.
  - `fill` (3 bits, 0–7): number of valid bytes in `acc`.
  - FSM `{ACCUM, FLUSH}`.
  - Output register holding `out_*`.
- `out_free = !out_valid || out_ready`.
- `emit = out_free && ((state==ACCUM && fill>=4) || state==FLUSH)`.
- `in_ready = state==ACCUM && (fill<4 || emit)`.
  - This path is combinational from `out_ready`; it is the only combinational in→out path.
- On `emit` in ACCUM:
  - Load `out_data = acc[63:32]`, `out_bytes = 4`, `out_last = 0`.
  - Shift `acc` left by 32 with zero fill; `fill -= 4`.
- On accept, evaluated against the post-emit `fill` and `acc`:
  - Compute `Shifter(dataIn=in_data, len0=fill, len1=sat(in_len))`.
  - `acc |= dataOut`; `fill = addedLen[2:0]`.
  - Maximum resulting `fill` is 3+4 = 7, so `acc` never overflows.
- Accepting with `in_last` moves the FSM to FLUSH. The last beat is merged first.
- FLUSH, on each `emit`:
  - If `fill > 4`: emit 4 bytes with `out_last = 0`, shift `acc`, `fill -= 4`, stay in FLUSH.
  - Otherwise: emit `acc[63:32]` with `out_bytes = fill` and `out_last = 1`; clear `acc` and `fill`; return to ACCUM.
- Empty frame: if `fill == 0` on entry to FLUSH, emit one word with `out_data = 0`, `out_bytes = 0`, `out_last = 1`.
- Zero-length beats with `in_last = 0` are accepted with no effect.
- The output register holds `out_*` stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `out_data=0`, `out_bytes=0`, `out_last=0`, `acc=0`, `fill=0`, state ACCUM, hence `in_ready=1`.
  - Reset asserted mid-frame or mid-flush discards all held bytes; no tail word is emitted.

## Timing
- Latency: a beat accepted at edge N that makes `fill >= 4` produces `out_valid` after edge N+1, provided the output register is free.
- Throughput: one 4-byte input beat and one output word per cycle sustained.
- Back-pressure:
  - With `out_ready` low and the output register full, `in_ready` falls once `fill >= 4`.
  - Zero data loss and zero duplication.
- FLUSH drain:
  - Takes 1 or 2 emit cycles (2 when `fill > 4`).
  - `in_ready = 0` throughout.
  - The next frame can be accepted in the cycle after the last word loads.

## Structure
- Package `packer_pkg`:
  - `BYTES_PER_WORD = DATA_WIDTH/8`.
  - `FILL_W = 3`.
  - State enum `pack_state_t {ACCUM, FLUSH}`.
  - Saturation helper for `in_len`.
- Sub-module: one instance of the existing combinational `Shifter` (`DATA_WIDTH`, `LEN_WIDTH` passed through) for chunk alignment. No other sub-modules.

## Test plan
- Reset: hold `rst_n` low, then release → `out_valid=0`, `out_data=0`, `out_bytes=0`, `out_last=0`, `in_ready=1`.
- Four 1-byte beats `0xAA……`, `0xBB……`, `0xCC……`, `0xDD……` (last on the 4th) → one word `0xAABBCCDD`, `out_bytes=4`, `out_last=1`.
- Beats len 3 `0x112233xx`, then len 3 `0x445566xx` with `in_last` → `0x11223344`/`bytes 4`/`last 0`, then `0x55660000`/`bytes 2`/`last 1`.
- Continuous 4-byte beats with `out_ready` low for 10 cycles, then high:
  - `in_ready` drops within 2 cycles.
  - Output words match the input order exactly.
  - Once `out_ready` is high again, exactly 1 word/cycle.
- `in_len=0` with `in_last` on an empty packer → single word `0x00000000`, `out_bytes=0`, `out_last=1`; `in_len=9` is treated as 4.
- Assert `rst_n` during FLUSH with `fill=6` → outputs clear immediately, no `out_last` word, next frame packs from byte 0.
